// File: rtl/ripple_subtract_sequencer.sv
// Word-serial multi-precision subtractor: one N-bit ripple slice per clock.
// Optional registered zero flag via RIPPLE_SUB_SEQ_ZERO_EN.
module ripple_carry_subtractor #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] diff,
   output logic         bout
);

   logic [N:0] br;

   always_comb begin
      br    = '0;
      diff  = '0;
      br[0] = bin;
      for (int i = 0; i < N; i++) begin
         diff[i]  = a[i] ^ b[i] ^ br[i];
         br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
      end
      bout = br[N];
   end

endmodule

module ripple_subtract_sequencer #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 bin,
   output logic                 busy,
   output logic                 done,
   output logic [N*WORDS-1:0]   diff,
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
   output logic                 zero,
`endif
   output logic                 bout
);

   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  diff_q, diff_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          borrow_q, borrow_d;
   logic          bout_q, bout_d;
   logic          accept;

   logic [N-1:0]  s_a, s_b, s_diff;
   logic          s_bout;

`ifdef RIPPLE_SUB_SEQ_ZERO_EN
   logic          zero_q, zero_d;
   logic          zacc_q, zacc_d;
`endif

   ripple_carry_subtractor #(.N(N)) u_slice (
      .a    (s_a),
      .b    (s_b),
      .bin  (borrow_q),
      .diff (s_diff),
      .bout (s_bout)
   );

   always_comb begin
      s_a = '0;
      s_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == IW'(i)) begin
            s_a = a_q[i*N +: N];
            s_b = b_q[i*N +: N];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      accept   = 1'b0;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
      zero_d   = zero_q;
      zacc_d   = zacc_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) accept = 1'b1;
         end
         RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IW'(i)) diff_d[i*N +: N] = s_diff;
            end
            borrow_d = s_bout;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
            zacc_d = zacc_q & (s_diff == '0);
`endif
            if (idx_q == LAST) begin
               bout_d  = s_bout;
               state_d = DONE;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
               zero_d  = zacc_d;
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (start) accept = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // accept overrides the per-state defaults, covering back-to-back
      if (accept) begin
         state_d  = RUN;
         a_d      = a;
         b_d      = b;
         idx_d    = '0;
         borrow_d = bin;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
         zero_d   = 1'b0;
         zacc_d   = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
         zero_q   <= 1'b0;
         zacc_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
         zero_q   <= zero_d;
         zacc_q   <= zacc_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
   assign zero = zero_q;
`endif

endmodule

// File: tb/tb_ripple_subtract_sequencer.sv
// Directed bench for ripple_subtract_sequencer, N=4 WORDS=4.
module tb_ripple_subtract_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        bout;
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
   logic        zero;
`endif

   int n_run;
   int n_fail;

   ripple_subtract_sequencer #(.N(4), .WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
      .zero  (zero),
`endif
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // hold=1 keeps start asserted with all-ones operands during RUN
   task automatic op(input string tag, input logic [15:0] va,
                     input logic [15:0] vb, input logic vbin,
                     input logic [15:0] ed, input logic eb,
                     input logic ez, input logic hold);
      start = 1'b1;
      a     = va;
      b     = vb;
      bin   = vbin;
      tick();
      if (hold) begin
         a = 16'hFFFF;
         b = 16'hFFFF;
      end else begin
         start = 1'b0;
         a     = 16'hDEAD;
         b     = 16'hBEEF;
      end
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done0"}, {31'd0, done}, 32'd0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk({tag, "_busyk"}, {31'd0, busy}, 32'd1);
      end
      tick();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_d"}, {31'd0, busy}, 32'd0);
      chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
      chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef RIPPLE_SUB_SEQ_ZERO_EN
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
`else
      if (ez) n_run = n_run + 0;
`endif
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      start  = 1'b1;
      a      = 16'h5555;
      b      = 16'h1111;
      bin    = 1'b1;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {16'd0, diff}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);

      op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      tick();
      chk("basic_idle", {31'd0, done | busy}, 32'd0);
      chk("basic_hold", {16'd0, diff}, 32'h1000);

      op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick();
      op("binz", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();

      op("ign", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);
      op("ign2", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      op("b2b", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
      tick();

      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'h0000;
      bin   = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_part", {24'd0, diff[7:0]}, 32'h00FF);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_diff", {16'd0, diff}, 32'd0);
      chk("mrst_bout", {31'd0, bout}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("mrst_nodone", {31'd0, done}, 32'd0);
      end

      op("post", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
